// File: rtl/mul_div_unit.sv
// MIPS EX-stage multiply/divide unit with architectural HI/LO registers.
// The result is computed at accept time and committed after a fixed per-class latency.
module mul_div_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cancel,
  input  logic [3:0]       opt,
  input  logic [WIDTH-1:0] v1,
  input  logic [WIDTH-1:0] v2,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] res
);

  localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE, RUN} state_t;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MFHI  = 4'd6,
    OP_MFLO  = 4'd7
  } op_t;

  state_t             state, state_next;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   pend_hi, pend_lo;
  logic               accept, load_md, finish;
  logic [CW-1:0]      lat_load;

  // ---------------------------------------------------------------------------
  // Arithmetic datapath
  // ---------------------------------------------------------------------------
  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic                      v1_neg, v2_neg, is_sdiv;
  logic        [WIDTH-1:0]   v1_mag, v2_mag, div_a, div_b;
  logic        [WIDTH-1:0]   q_u, r_u, q_s, r_s;
  logic        [2*WIDTH-1:0] calc;

  assign prod_s = $signed(v1) * $signed(v2);
  assign prod_u = {{WIDTH{1'b0}}, v1} * {{WIDTH{1'b0}}, v2};

  // Signed division runs on magnitudes; MIN_INT's magnitude fits as an unsigned value,
  // so MIN_INT / -1 wraps back to MIN_INT without special handling.
  assign v1_neg  = v1[WIDTH-1];
  assign v2_neg  = v2[WIDTH-1];
  assign is_sdiv = (opt == OP_DIV);
  assign v1_mag  = v1_neg ? -v1 : v1;
  assign v2_mag  = v2_neg ? -v2 : v2;
  assign div_a   = is_sdiv ? v1_mag : v1;
  assign div_b   = is_sdiv ? v2_mag : v2;
  assign q_u     = div_a / div_b;
  assign r_u     = div_a % div_b;
  assign q_s     = (v1_neg ^ v2_neg) ? -q_u : q_u;
  assign r_s     = v1_neg ? -r_u : r_u;

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    calc = '0;
    case (opt)
      OP_MULT:  calc = prod_s;
      OP_MULTU: calc = prod_u;
      OP_DIV:   calc = (v2 == '0) ? {v1, {WIDTH{1'b1}}} : {r_s, q_s};
      OP_DIVU:  calc = (v2 == '0) ? {v1, {WIDTH{1'b1}}} : {r_u, q_u};
      default:  calc = '0;
    endcase
  end

  assign lat_load = (opt == OP_DIV || opt == OP_DIVU) ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    accept     = start && !cancel && (state == IDLE);
    load_md    = accept && (opt < 4'd4);
    finish     = (state == RUN) && (count == CW'(1));
    case (state)
      IDLE:    if (load_md) state_next = RUN;
      RUN:     if (finish)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= state_next;

      if (load_md) begin
        pend_hi <= calc[2*WIDTH-1:WIDTH];
        pend_lo <= calc[WIDTH-1:0];
        count   <= lat_load;
      end else if (state == RUN) begin
        count <= count - CW'(1);
      end

      // accept only fires in IDLE and finish only in RUN, so these never collide.
      if (finish) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end else if (accept && opt == OP_MTHI) begin
        hi <= v1;
      end else if (accept && opt == OP_MTLO) begin
        lo <= v1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Move-from read port
  // ---------------------------------------------------------------------------
  always_comb begin
    res = '0;
    if (opt == OP_MFHI)      res = hi;
    else if (opt == OP_MFLO) res = lo;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: arithmetic/timeline model compared every cycle,
// plus hand-computed literal results for the directed vectors.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        cancel;
  logic [3:0]  opt;
  logic [31:0] v1, v2;
  logic        busy;
  logic [31:0] hi, lo, res;

  int n_vec = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  mul_div_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .cancel (cancel),
    .opt    (opt),
    .v1     (v1),
    .v2     (v2),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .res    (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic in plain 64-bit integer math.
  function automatic logic [63:0] model_md(input logic [3:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    t  = '0;
    case (o)
      4'd0: t = 64'(sa * sb);
      4'd1: t = ua * ub;
      4'd2: begin
        if (b == 32'd0) t = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          t = {r[31:0], q[31:0]};
        end
      end
      4'd3: begin
        if (b == 32'd0) t = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          t  = {ur[31:0], uq[31:0]};
        end
      end
      default: t = '0;
    endcase
    return t;
  endfunction

  // Timeline model: a mult/div accepted when the cycle index is k keeps the unit busy
  // until cycle k+1+LAT; before that the previous HI/LO stay visible.
  int          cyc, m_done;
  logic [31:0] p_hi, p_lo, a_hi, a_lo;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc    <= 0;
      m_done <= 0;
      p_hi   <= '0;
      p_lo   <= '0;
      a_hi   <= '0;
      a_lo   <= '0;
    end else begin
      cyc <= cyc + 1;
      if (start && !cancel && cyc >= m_done) begin
        case (opt)
          4'd0, 4'd1, 4'd2, 4'd3: begin
            a_hi         <= p_hi;
            a_lo         <= p_lo;
            {p_hi, p_lo} <= model_md(opt, v1, v2);
            m_done       <= cyc + 1 + ((opt >= 4'd2) ? 10 : 5);
          end
          4'd4:    p_hi <= v1;
          4'd5:    p_lo <= v1;
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one op starting at posedge+2; returns with inputs idle at posedge+2 once busy is low.
  task automatic op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                    output int n);
    start = 1'b1;
    opt   = o;
    v1    = a;
    v2    = b;
    @(posedge clk); #2;
    start = 1'b0;
    opt   = 4'd8;
    n     = 0;
    while (busy && n < 200) begin
      n++;
      @(posedge clk); #2;
    end
  endtask

  int n;

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    cancel = 1'b0;
    opt    = 4'd8;
    v1     = '0;
    v2     = '0;

    fork
      forever begin
        logic        eb;
        logic [31:0] eh, el, er;
        @(negedge clk);
        if (chk_en && !reset) begin
          eb = (cyc < m_done);
          eh = eb ? a_hi : p_hi;
          el = eb ? a_lo : p_lo;
          er = (opt == 4'd6) ? eh : (opt == 4'd7) ? el : 32'd0;
          check("cyc_busy", 64'(busy), 64'(eb));
          check("cyc_hi",   64'(hi),   64'(eh));
          check("cyc_lo",   64'(lo),   64'(el));
          check("cyc_res",  64'(res),  64'(er));
        end
      end
    join_none

    #1 reset = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi",   64'(hi),   64'd0);
    check("rst_lo",   64'(lo),   64'd0);
    @(posedge clk); #2;
    reset  = 1'b0;
    chk_en = 1'b1;

    op(4'd0, 32'hFFFF_FFFE, 32'd3, n);
    check("mult_lat", 64'(n),  64'd5);
    check("mult_hi",  64'(hi), 64'hFFFF_FFFF);
    check("mult_lo",  64'(lo), 64'hFFFF_FFFA);

    op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    check("multu_lat", 64'(n),  64'd5);
    check("multu_hi",  64'(hi), 64'hFFFF_FFFE);
    check("multu_lo",  64'(lo), 64'h0000_0001);

    op(4'd2, 32'hFFFF_FFF9, 32'd2, n);
    check("div_lat", 64'(n),  64'd10);
    check("div_hi",  64'(hi), 64'hFFFF_FFFF);
    check("div_lo",  64'(lo), 64'hFFFF_FFFD);

    op(4'd3, 32'd7, 32'd0, n);
    check("divu0_lat", 64'(n),  64'd10);
    check("divu0_hi",  64'(hi), 64'h0000_0007);
    check("divu0_lo",  64'(lo), 64'hFFFF_FFFF);

    op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("divmin_hi", 64'(hi), 64'h0000_0000);
    check("divmin_lo", 64'(lo), 64'h8000_0000);

    op(4'd4, 32'h0000_1234, 32'd0, n);
    opt = 4'd6;
    #1;
    check("mfhi_res",  64'(res),  64'h0000_1234);
    check("mthi_busy", 64'(busy), 64'd0);
    opt = 4'd8;
    @(posedge clk); #2;

    // MTLO offered while a MULT is in flight must be dropped.
    start = 1'b1; opt = 4'd0; v1 = 32'd2; v2 = 32'd3;
    @(posedge clk); #2;
    opt = 4'd5; v1 = 32'hDEAD_BEEF;
    @(posedge clk); #2;
    start = 1'b0; opt = 4'd8;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(posedge clk); #2;
    end
    check("mtlo_busy_lat", 64'(n),  64'd4);
    check("mtlo_busy_hi",  64'(hi), 64'h0000_0000);
    check("mtlo_busy_lo",  64'(lo), 64'h0000_0006);

    start = 1'b1; cancel = 1'b1; opt = 4'd0; v1 = 32'd5; v2 = 32'd5;
    @(posedge clk); #2;
    check("cancel_busy", 64'(busy), 64'd0);
    start = 1'b0; cancel = 1'b0; opt = 4'd8;
    check("cancel_hi", 64'(hi), 64'h0000_0000);
    check("cancel_lo", 64'(lo), 64'h0000_0006);

    // Asynchronous reset in the middle of a DIV.
    start = 1'b1; opt = 4'd2; v1 = 32'd100; v2 = 32'd7;
    @(posedge clk); #2;
    start = 1'b0; opt = 4'd8;
    repeat (3) begin
      @(posedge clk); #2;
    end
    #1 reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_hi",   64'(hi),   64'd0);
    check("arst_lo",   64'(lo),   64'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    op(4'd0, 32'd3, 32'd4, n);
    check("post_rst_lat", 64'(n),  64'd5);
    check("post_rst_hi",  64'(hi), 64'h0000_0000);
    check("post_rst_lo",  64'(lo), 64'h0000_000C);

    @(posedge clk); #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
